// File: rtl/sram_sp_init.sv
// Single-port SRAM model with byte enables, a user sideband per word, and a
// self-clearing sweep that zeroes every word after each reset.
module sram_sp_init #(
    parameter int unsigned ADDR_WIDTH = 64,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned USER_WIDTH = 10,
    parameter int unsigned NUM_WORDS  = 1024
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    req_i,
    input  logic                    we_i,
    input  logic [ADDR_WIDTH-1:0]   addr_i,
    input  logic [DATA_WIDTH/8-1:0] be_i,
    input  logic [USER_WIDTH-1:0]   user_i,
    input  logic [DATA_WIDTH-1:0]   data_i,
    output logic [DATA_WIDTH-1:0]   data_o,
    output logic [USER_WIDTH-1:0]   user_o,
    output logic                    init_done_o
);

    localparam int unsigned NR_BYTES     = DATA_WIDTH / 8;
    localparam int unsigned LOG_NR_BYTES = $clog2(NR_BYTES);
    localparam int unsigned IDX_W        = $clog2(NUM_WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);
    localparam logic [IDX_W-1:0] ONE_IDX  = IDX_W'(1);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e state_r;
    state_e state_next_s;

    logic [IDX_W-1:0]      init_cnt_r;
    logic [IDX_W-1:0]      addr_idx_s;
    logic                  addr_unused_s;

    logic                  mem_we_s;
    logic                  mem_user_we_s;
    logic [IDX_W-1:0]      mem_idx_s;
    logic [NR_BYTES-1:0]   mem_be_s;
    logic [DATA_WIDTH-1:0] mem_wdata_s;
    logic [USER_WIDTH-1:0] mem_wuser_s;
    logic                  rd_en_s;

    logic [DATA_WIDTH-1:0] mem_data_r [NUM_WORDS];
    logic [USER_WIDTH-1:0] mem_user_r [NUM_WORDS];

    // Upper address bits alias and the in-word byte offset is irrelevant.
    assign addr_idx_s    = addr_i[LOG_NR_BYTES +: IDX_W];
    assign addr_unused_s = ^addr_i;

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r <= ST_INIT;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state: leave INIT on the cycle the last word is cleared.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_INIT: begin
                if (init_cnt_r == LAST_IDX) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_INIT;
                end
            end
            ST_RUN: begin
                state_next_s = ST_RUN;
            end
            default: begin
                state_next_s = ST_INIT;
            end
        endcase
    end

    // Sweep pointer, advancing once per INIT cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            init_cnt_r <= {IDX_W{1'b0}};
        end else if (state_r == ST_INIT) begin
            init_cnt_r <= init_cnt_r + ONE_IDX;
        end else begin
            init_cnt_r <= init_cnt_r;
        end
    end

    // Output decode: sweep writes in INIT, host requests only in RUN.
    always_comb begin
        mem_we_s      = 1'b0;
        mem_user_we_s = 1'b0;
        mem_idx_s     = {IDX_W{1'b0}};
        mem_be_s      = {NR_BYTES{1'b0}};
        mem_wdata_s   = {DATA_WIDTH{1'b0}};
        mem_wuser_s   = {USER_WIDTH{1'b0}};
        rd_en_s       = 1'b0;
        case (state_r)
            ST_INIT: begin
                mem_we_s      = 1'b1;
                mem_user_we_s = 1'b1;
                mem_idx_s     = init_cnt_r;
                mem_be_s      = {NR_BYTES{1'b1}};
            end
            ST_RUN: begin
                mem_we_s      = req_i & we_i;
                mem_user_we_s = req_i & we_i & (|be_i);
                mem_idx_s     = addr_idx_s;
                mem_be_s      = be_i;
                mem_wdata_s   = data_i;
                mem_wuser_s   = user_i;
                rd_en_s       = req_i & ~we_i;
            end
            default: begin
                mem_we_s = 1'b0;
            end
        endcase
    end

    assign init_done_o = (state_r == ST_RUN);

    // Storage array; deliberately not reset, the sweep clears it.
    always_ff @(posedge clk_i) begin
        if (mem_we_s) begin
            for (int b = 0; b < NR_BYTES; b++) begin
                if (mem_be_s[b]) begin
                    mem_data_r[mem_idx_s][b*8 +: 8] <= mem_wdata_s[b*8 +: 8];
                end
            end
        end
        if (mem_user_we_s) begin
            mem_user_r[mem_idx_s] <= mem_wuser_s;
        end
    end

    // Read port: outputs only move on a RUN read, otherwise hold.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_o <= {DATA_WIDTH{1'b0}};
            user_o <= {USER_WIDTH{1'b0}};
        end else if (rd_en_s) begin
            data_o <= mem_data_r[mem_idx_s];
            user_o <= mem_user_r[mem_idx_s];
        end else begin
            data_o <= data_o;
            user_o <= user_o;
        end
    end

endmodule

// File: tb/tb_sram_sp_init.sv
// Directed bench for sram_sp_init with a 16-word, 64-bit configuration.
module tb_sram_sp_init;

    localparam int unsigned AW = 64;
    localparam int unsigned DW = 64;
    localparam int unsigned UW = 10;
    localparam int unsigned NW = 16;

    logic          clk;
    logic          rst_n;
    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [7:0]    be;
    logic [UW-1:0] user_in;
    logic [DW-1:0] wdata;
    logic [DW-1:0] data_out;
    logic [UW-1:0] user_out;
    logic          init_done;

    int checks;
    int errors;

    sram_sp_init #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .USER_WIDTH(UW),
        .NUM_WORDS (NW)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .req_i      (req),
        .we_i       (we),
        .addr_i     (addr),
        .be_i       (be),
        .user_i     (user_in),
        .data_i     (wdata),
        .data_o     (data_out),
        .user_o     (user_out),
        .init_done_o(init_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Each helper drives one request across one rising edge and returns #1 after it.
    task automatic do_write(input logic [AW-1:0] a, input logic [7:0] b,
                            input logic [DW-1:0] d, input logic [UW-1:0] u);
        req = 1'b1; we = 1'b1; addr = a; be = b; wdata = d; user_in = u;
        @(posedge clk); #1;
        req = 1'b0; we = 1'b0;
    endtask

    task automatic do_read(input logic [AW-1:0] a);
        req = 1'b1; we = 1'b0; addr = a; be = 8'h00;
        @(posedge clk); #1;
        req = 1'b0;
    endtask

    task automatic idle_cycle();
        req = 1'b0; we = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        int n;
        rst_n = 1'b0;
        #2;
        checks++;
        if (init_done !== 1'b0 || data_out !== 64'h0 || user_out !== 10'h0) begin
            errors++;
            $display("FAIL reset_state: init_done=%b data=%h user=%h, want 0/0/0", init_done, data_out, user_out);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        checks++;
        if (init_done !== 1'b0) begin
            errors++;
            $display("FAIL init_start: init_done=%b, want 0", init_done);
        end
        n = 0;
        while (init_done !== 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (n != 16) begin
            errors++;
            $display("FAIL init_length: edges until done=%0d, want 16", n);
        end
        do_read(64'h28);
        checks++;
        if (data_out !== 64'h0 || user_out !== 10'h0) begin
            errors++;
            $display("FAIL init_zero_word5: data=%h user=%h, want 0/0", data_out, user_out);
        end
    endtask

    task automatic test_full_write();
        do_write(64'h28, 8'hFF, 64'hDEADBEEF_CAFEF00D, 10'h2A);
        checks++;
        if (data_out !== 64'h0) begin
            errors++;
            $display("FAIL write_no_output: data=%h, want 0", data_out);
        end
        do_read(64'h28);
        checks++;
        if (data_out !== 64'hDEADBEEF_CAFEF00D || user_out !== 10'h2A) begin
            errors++;
            $display("FAIL full_write: data=%h user=%h, want deadbeefcafef00d/02a", data_out, user_out);
        end
    endtask

    task automatic test_partial_write();
        do_write(64'h28, 8'h0F, 64'h11111111_22222222, 10'h15);
        do_read(64'h28);
        checks++;
        if (data_out !== 64'hDEADBEEF_22222222 || user_out !== 10'h15) begin
            errors++;
            $display("FAIL partial_write: data=%h user=%h, want deadbeef22222222/015", data_out, user_out);
        end
        do_read(64'h2D);
        checks++;
        if (data_out !== 64'hDEADBEEF_22222222) begin
            errors++;
            $display("FAIL low_addr_bits: data=%h, want deadbeef22222222", data_out);
        end
    endtask

    task automatic test_alias_and_be0();
        do_write(64'h80, 8'hFF, 64'h5A, 10'h003);
        do_read(64'h0);
        checks++;
        if (data_out !== 64'h5A || user_out !== 10'h003) begin
            errors++;
            $display("FAIL alias_word0: data=%h user=%h, want 5a/003", data_out, user_out);
        end
        do_write(64'h0, 8'h00, 64'hFFFFFFFF_FFFFFFFF, 10'h1FF);
        do_read(64'h0);
        checks++;
        if (data_out !== 64'h5A || user_out !== 10'h003) begin
            errors++;
            $display("FAIL be_zero_noop: data=%h user=%h, want 5a/003", data_out, user_out);
        end
    endtask

    task automatic test_back_to_back();
        do_write(64'h08, 8'hFF, 64'h1111, 10'h001);
        do_write(64'h10, 8'hF0, 64'h22220000_00002222, 10'h002);
        do_write(64'h18, 8'h01, 64'h33, 10'h003);
        do_read(64'h08);
        checks++;
        if (data_out !== 64'h1111 || user_out !== 10'h001) begin
            errors++;
            $display("FAIL b2b_word1: data=%h user=%h, want 1111/001", data_out, user_out);
        end
        do_read(64'h10);
        checks++;
        if (data_out !== 64'h22220000_00000000 || user_out !== 10'h002) begin
            errors++;
            $display("FAIL b2b_word2: data=%h user=%h, want 2222000000000000/002", data_out, user_out);
        end
        do_read(64'h18);
        checks++;
        if (data_out !== 64'h33 || user_out !== 10'h003) begin
            errors++;
            $display("FAIL b2b_word3: data=%h user=%h, want 33/003", data_out, user_out);
        end
    endtask

    task automatic test_hold();
        do_read(64'h28);
        for (int i = 0; i < 3; i++) begin
            idle_cycle();
            checks++;
            if (data_out !== 64'hDEADBEEF_22222222 || user_out !== 10'h15) begin
                errors++;
                $display("FAIL hold_idle%0d: data=%h user=%h, want deadbeef22222222/015", i, data_out, user_out);
            end
        end
        do_write(64'h28, 8'hFF, 64'h0123456789ABCDEF, 10'h3C);
        do_write(64'h28, 8'h80, 64'hAA000000_00000000, 10'h3D);
        checks++;
        if (data_out !== 64'hDEADBEEF_22222222 || user_out !== 10'h15) begin
            errors++;
            $display("FAIL hold_writes: data=%h user=%h, want deadbeef22222222/015", data_out, user_out);
        end
        do_read(64'h28);
        checks++;
        if (data_out !== 64'hAA23456789ABCDEF || user_out !== 10'h3D) begin
            errors++;
            $display("FAIL after_hold_read: data=%h user=%h, want aa23456789abcdef/03d", data_out, user_out);
        end
    endtask

    task automatic test_reset_in_run();
        int n;
        int bad;
        rst_n = 1'b0;
        req = 1'b1; we = 1'b1; addr = 64'h08; be = 8'hFF; wdata = 64'hBAD; user_in = 10'h0BA;
        #1;
        checks++;
        if (data_out !== 64'h0 || user_out !== 10'h0 || init_done !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: data=%h user=%h done=%b, want 0/0/0", data_out, user_out, init_done);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        req = 1'b0; we = 1'b0;
        n = 0;
        while (init_done !== 1'b1 && n < 100) begin
            // Past word 2 of the sweep, try a write and a read that must be ignored.
            if (n == 8) begin
                req = 1'b1; we = 1'b1; addr = 64'h10; be = 8'hFF; wdata = 64'hFACE; user_in = 10'h0FA;
            end else if (n == 9) begin
                req = 1'b1; we = 1'b0; addr = 64'h28;
            end else begin
                req = 1'b0; we = 1'b0;
            end
            @(posedge clk); #1;
            n++;
        end
        req = 1'b0; we = 1'b0;
        checks++;
        if (n != 16) begin
            errors++;
            $display("FAIL reinit_length: edges until done=%0d, want 16", n);
        end
        checks++;
        if (data_out !== 64'h0 || user_out !== 10'h0) begin
            errors++;
            $display("FAIL init_read_ignored: data=%h user=%h, want 0/0", data_out, user_out);
        end
        bad = 0;
        for (int w = 0; w < 16; w++) begin
            do_read(64'(w) << 3);
            if (data_out !== 64'h0 || user_out !== 10'h0) begin
                bad++;
            end
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL reinit_all_zero: nonzero words=%0d, want 0", bad);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        req = 1'b0; we = 1'b0; addr = '0; be = 8'h00; user_in = '0; wdata = '0;
        rst_n = 1'b1;
        test_reset();
        test_full_write();
        test_partial_write();
        test_alias_and_be0();
        test_back_to_back();
        test_hold();
        test_reset_in_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
